// File: rtl/enemy_lane_mover.sv
// enemy_lane_mover: horizontal mover for one enemy sprite.
// While UpdateEnemy is high, a rate counter runs and every (PERIOD >> speed_sel)
// enabled cycles x steps one pixel in the current direction and
// doneUpdateEnemy pulses for one cycle. restart reloads the start position.
// Optional feature macro: ENEMY_BOUNCE_EN (defined: reflect at the limits,
// undefined: wrap to the opposite limit with a fixed direction).
//
// Handshake: UpdateEnemy is a level request held by the control FSM until it
// sees doneUpdateEnemy; doneUpdateEnemy is a registered one-cycle pulse issued
// on the cycle after the edge where a step (or reflection) is committed.

module enemy_lane_mover #(
    parameter int         X_W       = 8,
    parameter int         Y_W       = 7,
    parameter int         START_X   = 130,
    parameter int         START_Y   = 85,
    parameter int         LEFT_LIM  = 0,
    parameter int         RIGHT_LIM = 159,
    parameter int         START_DIR = 0,
    parameter int         PERIOD    = 250000,
    parameter int         CNT_W     = 18,
    parameter logic [2:0] COLOUR    = 3'b100
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           restart,
    input  logic           UpdateEnemy,
    input  logic [1:0]     speed_sel,
    output logic [2:0]     enemy_colour,
    output logic           doneUpdateEnemy,
    output logic [X_W-1:0] enemy_x,
    output logic [Y_W-1:0] enemy_y,
    output logic           enemy_dir
);

    localparam logic [X_W-1:0]   START_X_V = X_W'(START_X);
    localparam logic [Y_W-1:0]   START_Y_V = Y_W'(START_Y);
    localparam logic [X_W-1:0]   LEFT_V    = X_W'(LEFT_LIM);
    localparam logic [X_W-1:0]   RIGHT_V   = X_W'(RIGHT_LIM);
    localparam logic             DIR_V     = 1'(START_DIR);
    localparam logic [X_W-1:0]   ONE_X     = X_W'(1);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    // Terminal counts for the four speed settings (count runs 0..T).
    localparam logic [CNT_W-1:0] T0 = CNT_W'((PERIOD >> 0) - 1);
    localparam logic [CNT_W-1:0] T1 = CNT_W'((PERIOD >> 1) - 1);
    localparam logic [CNT_W-1:0] T2 = CNT_W'((PERIOD >> 2) - 1);
    localparam logic [CNT_W-1:0] T3 = CNT_W'((PERIOD >> 3) - 1);

    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic [X_W-1:0]   x_q,    x_d;
    logic [Y_W-1:0]   y_q,    y_d;
    logic             dir_q,  dir_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] target;

    // Select the terminal count; a speed change applies on the very next edge.
    always_comb begin
        target = T0;
        case (speed_sel)
            2'd0:    target = T0;
            2'd1:    target = T1;
            2'd2:    target = T2;
            default: target = T3;
        endcase
    end

    // Next-state: restart beats the request; a paused request freezes the count.
    always_comb begin
        cnt_d  = cnt_q;
        x_d    = x_q;
        y_d    = y_q;
        dir_d  = dir_q;
        done_d = 1'b0;
        if (restart) begin
            cnt_d = '0;
            x_d   = START_X_V;
            y_d   = START_Y_V;
            dir_d = DIR_V;
        end else if (UpdateEnemy) begin
            if (cnt_q < target) begin
                cnt_d = cnt_q + ONE_C;
            end else begin
                cnt_d  = '0;
                done_d = 1'b1;
`ifdef ENEMY_BOUNCE_EN
                if (!dir_q) begin
                    if (x_q == LEFT_V) begin
                        dir_d = 1'b1;
                        x_d   = LEFT_V + ONE_X;
                    end else begin
                        x_d = x_q - ONE_X;
                    end
                end else begin
                    if (x_q == RIGHT_V) begin
                        dir_d = 1'b0;
                        x_d   = RIGHT_V - ONE_X;
                    end else begin
                        x_d = x_q + ONE_X;
                    end
                end
`else
                if (!dir_q) begin
                    x_d = (x_q == LEFT_V) ? RIGHT_V : (x_q - ONE_X);
                end else begin
                    x_d = (x_q == RIGHT_V) ? LEFT_V : (x_q + ONE_X);
                end
`endif
            end
        end
    end

    // State registers with asynchronous reload to the start position.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            x_q    <= START_X_V;
            y_q    <= START_Y_V;
            dir_q  <= DIR_V;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            x_q    <= x_d;
            y_q    <= y_d;
            dir_q  <= dir_d;
            done_q <= done_d;
        end
    end

    assign enemy_colour    = COLOUR;
    assign doneUpdateEnemy = done_q;
    assign enemy_x         = x_q;
    assign enemy_y         = y_q;
    assign enemy_dir       = dir_q;

endmodule

// File: tb/tb_enemy_lane_mover.sv
// Bench for enemy_lane_mover with PERIOD=8, CNT_W=4. A second instance starts
// at x=0 to exercise the left limit. Expected x values and pulse cycles are
// queued when stimulus is applied and popped when a done pulse appears.

module tb_enemy_lane_mover;

  logic       clk = 1'b0;
  logic       reset;
  logic       restart, restart2;
  logic       upd, upd2;
  logic [1:0] speed_sel;

  logic [2:0] colour, colour2;
  logic       done, done2;
  logic [7:0] x, x2;
  logic [6:0] y, y2;
  logic       dir, dir2;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  int         exp_cyc_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  enemy_lane_mover #(.START_X(130), .PERIOD(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .restart(restart), .UpdateEnemy(upd),
    .speed_sel(speed_sel), .enemy_colour(colour), .doneUpdateEnemy(done),
    .enemy_x(x), .enemy_y(y), .enemy_dir(dir)
  );

  enemy_lane_mover #(.START_X(0), .PERIOD(8), .CNT_W(4)) dut_left (
    .clk(clk), .reset(reset), .restart(restart2), .UpdateEnemy(upd2),
    .speed_sel(speed_sel), .enemy_colour(colour2), .doneUpdateEnemy(done2),
    .enemy_x(x2), .enemy_y(y2), .enemy_dir(dir2)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; restart = 1'b0; restart2 = 1'b0;
    upd = 1'b0; upd2 = 1'b0; speed_sel = 2'd0;
    repeat (2) tick();
    reset = 1'b0;
    upd = 1'b1; speed_sel = 2'd3;
    repeat (5) tick();
    // mid-cycle asynchronous reset, no clock edge before the check
    reset = 1'b1;
    #1;
    checks++; if (x !== 8'd130) begin failures++; $display("FAIL reset_x got=%0d exp=130", x); end
    checks++; if (y !== 7'd85) begin failures++; $display("FAIL reset_y got=%0d exp=85", y); end
    checks++; if (dir !== 1'b0) begin failures++; $display("FAIL reset_dir got=%0b exp=0", dir); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
    checks++; if (colour !== 3'b100) begin failures++; $display("FAIL colour got=%b exp=100", colour); end
    upd = 1'b0; speed_sel = 2'd0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_speed0();
    int n;
    exp_q.push_back(8'd129); exp_cyc_q.push_back(8);
    exp_q.push_back(8'd128); exp_cyc_q.push_back(16);
    exp_q.push_back(8'd127); exp_cyc_q.push_back(24);
    speed_sel = 2'd0;
    upd = 1'b1;
    n = 0;
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (done) begin
        n++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL speed0_extra_done cycle=%0d x=%0d exp=none", i, x);
        end else begin
          logic [7:0] ex;
          int ec;
          ex = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          if (x !== ex) begin failures++; $display("FAIL speed0_x got=%0d exp=%0d", x, ex); end
          checks++;
          if (i != ec) begin failures++; $display("FAIL speed0_cycle got=%0d exp=%0d", i, ec); end
        end
      end
    end
    upd = 1'b0;
    checks++;
    if (n != 3) begin failures++; $display("FAIL speed0_pulses got=%0d exp=3", n); end
    exp_q.delete(); exp_cyc_q.delete();
  endtask

  task automatic test_fast();
    logic [7:0] ex;
    // T=0: one step every enabled cycle
    for (int k = 0; k < 4; k++) exp_q.push_back(8'(126 - k));
    speed_sel = 2'd3;
    upd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      ex = exp_q.pop_front();
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL fast_done cycle=%0d got=%0b exp=1", i, done); end
      checks++; if (x !== ex) begin failures++; $display("FAIL fast_x got=%0d exp=%0d", x, ex); end
    end
    // count to 5 at speed 0, then switch to speed 2 (T=1): step immediately
    speed_sel = 2'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL cnt5_done cycle=%0d got=%0b exp=0", i, done); end
    end
    speed_sel = 2'd2;
    exp_q.push_back(8'd122);
    tick();
    ex = exp_q.pop_front();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL speedchg_done got=%0b exp=1", done); end
    checks++; if (x !== ex) begin failures++; $display("FAIL speedchg_x got=%0d exp=%0d", x, ex); end
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL speed2_gap got=%0b exp=0", done); end
    exp_q.push_back(8'd121);
    tick();
    ex = exp_q.pop_front();
    checks++; if (done !== 1'b1 || x !== ex) begin failures++; $display("FAIL speed2_step done=%0b x=%0d exp_x=%0d", done, x, ex); end
    upd = 1'b0;
    speed_sel = 2'd0;
  endtask

  task automatic test_pause();
    do_restart();
    checks++; if (x !== 8'd130 || done !== 1'b0) begin failures++; $display("FAIL restart_load x=%0d done=%0b exp=130/0", x, done); end
    upd = 1'b1;
    repeat (4) tick();
    upd = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (done !== 1'b0 || x !== 8'd130) begin failures++; $display("FAIL pause_hold cycle=%0d done=%0b x=%0d exp=0/130", i, done, x); end
    end
    upd = 1'b1;
    exp_q.push_back(8'd129);
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i < 4) begin
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL resume_early cycle=%0d got=%0b exp=0", i, done); end
      end else begin
        logic [7:0] ex;
        ex = exp_q.pop_front();
        checks++; if (done !== 1'b1 || x !== ex) begin failures++; $display("FAIL resume_step done=%0b x=%0d exp=1/%0d", done, x, ex); end
      end
    end
    upd = 1'b0;
  endtask

  task automatic test_restart_collision();
    do_restart();
    upd = 1'b1;
    repeat (7) tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    checks++; if (x !== 8'd130 || done !== 1'b0) begin failures++; $display("FAIL restart_collide x=%0d done=%0b exp=130/0", x, done); end
    exp_q.push_back(8'd129);
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (done) begin
        logic [7:0] ex;
        ex = exp_q.pop_front();
        checks++; if (i != 8 || x !== ex) begin failures++; $display("FAIL restart_after cycle=%0d x=%0d exp=8/%0d", i, x, ex); end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL restart_missing got=%0d exp=0 pending", exp_q.size()); end
    exp_q.delete();
    upd = 1'b0;
  endtask

  task automatic test_wrap();
    logic [7:0] ex;
    logic       ed;
    restart2 = 1'b1; tick(); restart2 = 1'b0;
    checks++; if (x2 !== 8'd0 || dir2 !== 1'b0) begin failures++; $display("FAIL left_load x=%0d dir=%0b exp=0/0", x2, dir2); end
`ifdef ENEMY_BOUNCE_EN
    exp_q.push_back(8'd1); exp_q.push_back(8'd2);
    ed = 1'b1;
`else
    exp_q.push_back(8'd159); exp_q.push_back(8'd158);
    ed = 1'b0;
`endif
    speed_sel = 2'd3;
    upd2 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      ex = exp_q.pop_front();
      checks++; if (done2 !== 1'b1) begin failures++; $display("FAIL edge_done step=%0d got=%0b exp=1", i, done2); end
      checks++; if (x2 !== ex || dir2 !== ed) begin failures++; $display("FAIL edge_step x=%0d dir=%0b exp=%0d/%0b", x2, dir2, ex, ed); end
    end
    upd2 = 1'b0;
    speed_sel = 2'd0;
  endtask

  initial begin
    test_reset();
    test_speed0();
    test_fast();
    test_pause();
    test_restart_collision();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
